// File: rtl/alu_exec.sv
// alu_exec: operand capture plus add / sub / mod-3 execution for the keyboard ALU.
// Latency: add, sub and pass-A one cycle after the event edge; mod-3 eight cycles (busy during 7 steps + 1 finalize).
// Backpressure: none; a new event aborts (MOD) or overrides (EXEC) the pending computation.
//
// Optional feature macro: ALU_EXEC_MOD3_EN
//   defined   -> sequential mod-3 unit and MOD state are built.
//   undefined -> op 010 is treated as pass-A and busy is tied low.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   a_in      operand input bus (switches)
//   reg_ctrl  bit0 loads A from a_in, bit1 loads B from a_in
//   func      bit3 signed mode; bits2:0 = 000 add, 001 sub, 010 mod3, others pass A
//   result    registered result
//   sign_out  result negative (signed add/sub only)
//   overflow  unsigned carry/borrow or signed overflow (add/sub only)
//   busy      mod-3 in progress
//   valid     one-cycle pulse when result and flags update
module alu_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [1:0]       reg_ctrl,
    input  logic [3:0]       func,
    output logic [WIDTH-1:0] result,
    output logic             sign_out,
    output logic             overflow,
    output logic             busy,
    output logic             valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MOD  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
`ifdef ALU_EXEC_MOD3_EN
    localparam logic [2:0] OP_MOD3 = 3'b010;
    localparam logic [WIDTH-1:0] ONE   = 1;
    localparam logic [WIDTH-1:0] THREE = 3;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       func_q, func_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

`ifdef ALU_EXEC_MOD3_EN
    logic [WIDTH-1:0] r_q, r_d;      // running remainder
    logic [2:0]       k_q, k_d;      // current shift of the 3<<k subtrahend
    logic             fin_q, fin_d;  // all 7 steps done, finalize next edge
    logic             neg_q, neg_d;  // signed operand was negative
`endif

    // ------------------------------------------------------------------
    // Event detection: any load strobe, or a change of function code
    // ------------------------------------------------------------------
    logic evt;
    assign evt = (|reg_ctrl) || (func != func_q);

    // ------------------------------------------------------------------
    // Single-cycle add/sub/pass datapath, operating on the captured regs
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] exec_res;
    logic             exec_sign;
    logic             exec_ovf;
    logic             sgn_mode;

    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign diff     = {1'b0, a_q} - {1'b0, b_q};
    assign sgn_mode = func_q[3];

    always_comb begin
        exec_res  = a_q;
        exec_sign = 1'b0;
        exec_ovf  = 1'b0;
        case (func_q[2:0])
            OP_ADD: begin
                exec_res  = sum[WIDTH-1:0];
                exec_sign = sgn_mode & sum[WIDTH-1];
                // signed: same-sign operands producing an opposite-sign sum
                exec_ovf  = sgn_mode ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                        (sum[WIDTH-1] != a_q[WIDTH-1]))
                                     : sum[WIDTH];
            end
            OP_SUB: begin
                exec_res  = diff[WIDTH-1:0];
                exec_sign = sgn_mode & diff[WIDTH-1];
                // signed: differing-sign operands where the result flips away from A
                // unsigned: the extra MSB is the borrow (A < B)
                exec_ovf  = sgn_mode ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                        (diff[WIDTH-1] != a_q[WIDTH-1]))
                                     : diff[WIDTH];
            end
            default: begin
                exec_res  = a_q;
                exec_sign = 1'b0;
                exec_ovf  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mod-3 restoring-subtraction step and start/finish values
    // ------------------------------------------------------------------
`ifdef ALU_EXEC_MOD3_EN
    logic [WIDTH:0]   thr;        // 3 << k, one bit wider so 3<<6 never truncates
    logic             step_ge;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] mod_res;
    logic             start_neg;
    logic [WIDTH-1:0] start_abs;

    assign thr     = {{(WIDTH-1){1'b0}}, 2'b11} << k_q;
    assign step_ge = ({1'b0, r_q} >= thr);
    assign r_step  = r_q - thr[WIDTH-1:0];

    // Negative signed operand: remainder of |A| is folded back to 0..2.
    assign mod_res = (neg_q && (r_q != '0)) ? (THREE - r_q) : r_q;

    // Start values use the operand as it will be after this edge's load,
    // and the signed bit from the incoming func (func_q loads on the same edge).
    // |-128| wraps to 0x80, which is the correct unsigned magnitude 128.
    assign start_neg = func[3] & a_d[WIDTH-1];
    assign start_abs = start_neg ? ((~a_d) + ONE) : a_d;
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        func_d   = func_q;
        result_d = result_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
`ifdef ALU_EXEC_MOD3_EN
        r_d      = r_q;
        k_d      = k_q;
        fin_d    = fin_q;
        neg_d    = neg_q;
`endif

        if (evt) begin
            // A new event always wins: a pending EXEC or MOD is dropped
            // without a valid pulse and restarted from this edge.
            if (reg_ctrl[0]) a_d = a_in;
            if (reg_ctrl[1]) b_d = a_in;
            func_d = func;
`ifdef ALU_EXEC_MOD3_EN
            if (func[2:0] == OP_MOD3) begin
                state_d = S_MOD;
                k_d     = 3'd6;
                fin_d   = 1'b0;
                r_d     = start_abs;
                neg_d   = start_neg;
            end else begin
                state_d = S_EXEC;
            end
`else
            state_d = S_EXEC;
`endif
        end else begin
            case (state_q)
                S_EXEC: begin
                    result_d = exec_res;
                    sign_d   = exec_sign;
                    ovf_d    = exec_ovf;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
`ifdef ALU_EXEC_MOD3_EN
                S_MOD: begin
                    if (fin_q) begin
                        result_d = mod_res;
                        sign_d   = 1'b0;
                        ovf_d    = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        if (step_ge) r_d = r_step;
                        if (k_q == 3'd0) begin
                            fin_d = 1'b1;
                        end else begin
                            k_d = k_q - 3'd1;
                        end
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

`ifdef ALU_EXEC_MOD3_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            k_q   <= 3'd0;
            fin_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            k_q   <= k_d;
            fin_q <= fin_d;
            neg_q <= neg_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign result   = result_q;
    assign sign_out = sign_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;
`ifdef ALU_EXEC_MOD3_EN
    assign busy     = (state_q == S_MOD);
`else
    assign busy     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in;
    logic [1:0] reg_ctrl;
    logic [3:0] func;
    logic [7:0] result;
    logic       sign_out;
    logic       overflow;
    logic       busy;
    logic       valid;

    int checks = 0;
    int errors = 0;

    alu_exec #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .reg_ctrl (reg_ctrl),
        .func     (func),
        .result   (result),
        .sign_out (sign_out),
        .overflow (overflow),
        .busy     (busy),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
        logic [7:0] res;
        logic       sg;
        logic       ov;
        int         lat;
    } vec_t;

    vec_t vecs[$];

`ifdef ALU_EXEC_MOD3_EN
    localparam int MOD_LAT = 8;
`else
    localparam int MOD_LAT = 1;
`endif

    task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                           input logic [7:0] res, input logic sg, input logic ov, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.f = f; v.res = res; v.sg = sg; v.ov = ov; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Mod-3 op: with the unit built the remainder arrives after 8 edges,
    // otherwise the op is pass-A after one edge.
    task automatic add_mod(input logic [7:0] a, input logic [3:0] f, input logic [7:0] rem);
`ifdef ALU_EXEC_MOD3_EN
        add_vec(a, 8'h00, f, rem, 1'b0, 1'b0, MOD_LAT);
`else
        add_vec(a, 8'h00, f, a, 1'b0, 1'b0, MOD_LAT);
`endif
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one edge and move 1 ns past it, away from the sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"},   result,   32'h0);
        chk({tag, "_sign"},     sign_out, 32'h0);
        chk({tag, "_overflow"}, overflow, 32'h0);
        chk({tag, "_busy"},     busy,     32'h0);
        chk({tag, "_valid"},    valid,    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_res;
        int         saw_valid;

        // --------------------------------------------------------------
        // Vector table: A, B, func, result, sign, overflow, latency
        // --------------------------------------------------------------
        add_vec(8'd100, 8'd200, 4'b0000, 8'd44,  1'b0, 1'b1, 1); // unsigned add carry
        add_vec(8'h80,  8'h01,  4'b1001, 8'h7F,  1'b0, 1'b1, 1); // signed sub overflow
        add_vec(8'hFF,  8'hFE,  4'b1000, 8'hFD,  1'b1, 1'b0, 1); // -1 + -2
        add_vec(8'd10,  8'd3,   4'b0000, 8'd13,  1'b0, 1'b0, 1);
        add_vec(8'd3,   8'd10,  4'b0001, 8'hF9,  1'b0, 1'b1, 1); // unsigned borrow
        add_vec(8'd10,  8'd3,   4'b0001, 8'd7,   1'b0, 1'b0, 1);
        add_vec(8'h7F,  8'h01,  4'b1000, 8'h80,  1'b1, 1'b1, 1); // signed add overflow
        add_vec(8'h05,  8'h07,  4'b1001, 8'hFE,  1'b1, 1'b0, 1); // 5 - 7 = -2
        add_vec(8'h42,  8'h11,  4'b0011, 8'h42,  1'b0, 1'b0, 1); // pass A
        add_vec(8'hC5,  8'h00,  4'b1111, 8'hC5,  1'b0, 1'b0, 1); // pass A, signed
        add_mod(8'd200, 4'b0010, 8'd2);
        add_mod(8'd255, 4'b0010, 8'd0);
        add_mod(8'd0,   4'b0010, 8'd0);
        add_mod(8'hF9,  4'b1010, 8'd2);   // -7 mod 3
        add_mod(8'h80,  4'b1010, 8'd1);   // -128 mod 3
        add_mod(8'h05,  4'b1010, 8'd2);

        // --------------------------------------------------------------
        // Reset state
        // --------------------------------------------------------------
        rst = 1'b1; a_in = 8'h00; reg_ctrl = 2'b00; func = 4'b0000;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk_all_zero("idle_after_reset");

        // --------------------------------------------------------------
        // Table-driven vectors: load A (event), load B (overriding event),
        // then wait the expected latency.
        // --------------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            a_in = v.a; reg_ctrl = 2'b01; func = v.f;
            tick();
            a_in = v.b; reg_ctrl = 2'b10;
            tick();
            reg_ctrl = 2'b00;
            chk($sformatf("v%0d_valid_overridden", i), valid, 32'h0);
            chk($sformatf("v%0d_busy_start", i), busy, (v.lat > 1) ? 32'h1 : 32'h0);
            for (int c = 1; c <= v.lat; c++) begin
                tick();
                if (c < v.lat) begin
                    chk($sformatf("v%0d_busy_c%0d", i, c), busy, 32'h1);
                    chk($sformatf("v%0d_early_valid_c%0d", i, c), valid, 32'h0);
                end
            end
            chk($sformatf("v%0d_valid", i),    valid,    32'h1);
            chk($sformatf("v%0d_busy_done", i), busy,    32'h0);
            chk($sformatf("v%0d_result", i),   result,   {24'h0, v.res});
            chk($sformatf("v%0d_sign", i),     sign_out, {31'h0, v.sg});
            chk($sformatf("v%0d_overflow", i), overflow, {31'h0, v.ov});
            tick();
            chk($sformatf("v%0d_valid_pulse", i), valid,  32'h0);
            chk($sformatf("v%0d_hold", i),        result, {24'h0, v.res});
        end
        last_res = vecs[vecs.size()-1].res;

`ifdef ALU_EXEC_MOD3_EN
        // --------------------------------------------------------------
        // Restart: A=10 strobed during the 3rd busy cycle of A=200
        // --------------------------------------------------------------
        a_in = 8'd200; reg_ctrl = 2'b01; func = 4'b0010;
        tick();
        reg_ctrl = 2'b00;
        saw_valid = 0;
        for (int c = 0; c < 2; c++) begin
            if (valid) saw_valid++;
            tick();
        end
        chk("restart_busy3", busy, 32'h1);
        chk("restart_hold_while_busy", result, {24'h0, last_res});
        a_in = 8'd10; reg_ctrl = 2'b01;
        tick();
        reg_ctrl = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            if (c < 8 && valid) saw_valid++;
            tick();
        end
        chk("restart_no_valid_for_old", saw_valid, 32'h0);
        chk("restart_valid", valid, 32'h1);
        chk("restart_result", result, 32'd1);
        chk("restart_busy_done", busy, 32'h0);
        tick();
        chk("restart_valid_pulse", valid, 32'h0);
`else
        // --------------------------------------------------------------
        // Mod-3 absent: op 010 is pass-A with single-cycle latency
        // --------------------------------------------------------------
        a_in = 8'd200; reg_ctrl = 2'b01; func = 4'b0010;
        tick();
        reg_ctrl = 2'b00;
        chk("nomod_busy_start", busy, 32'h0);
        tick();
        chk("nomod_valid", valid, 32'h1);
        chk("nomod_result", result, 32'd200);
        chk("nomod_busy", busy, 32'h0);
`endif

        // --------------------------------------------------------------
        // Reset during a mod-3 computation
        // --------------------------------------------------------------
        a_in = 8'd200; reg_ctrl = 2'b01; func = 4'b0010;
        tick();
        reg_ctrl = 2'b00;
        tick(); tick();
`ifdef ALU_EXEC_MOD3_EN
        chk("rstmid_busy_before", busy, 32'h1);
`endif
        rst = 1'b1; func = 4'b0000;
        tick();
        chk_all_zero("rstmid");
        rst = 1'b0;
        saw_valid = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (valid || busy) saw_valid++;
        end
        chk("rstmid_no_valid_after", saw_valid, 32'h0);

        // --------------------------------------------------------------
        // Reset beats a simultaneous load: A must stay 0, so 0 + 5 = 5
        // --------------------------------------------------------------
        rst = 1'b1; a_in = 8'd77; reg_ctrl = 2'b01; func = 4'b0000;
        tick();
        chk("rstprio_result", result, 32'h0);
        chk("rstprio_valid", valid, 32'h0);
        rst = 1'b0; a_in = 8'd5; reg_ctrl = 2'b10;
        tick();
        reg_ctrl = 2'b00;
        tick();
        chk("rstprio_valid_after", valid, 32'h1);
        chk("rstprio_sum", result, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
